tt_mux_sel_driver: RTL and testbench

- Drives the TinyTapeout mux control pins `ctrl_sel_rst_n`, `ctrl_sel_inc` and `ctrl_ena` from a simple request handshake. It is the selection-controller end of the mux control protocol, the role otherwise played by the demo-board MCU.
- Given a target design address, it disables the current design and resets or advances the mux address counter with timed pulses. It then settles and re-enables.
- Used in board-side FPGA test rigs and chip-level testbenches.

---
 rtl/tt_mux_sel_pkg.sv | 28 ++
 rtl/tt_mux_sel_timer.sv | 22 ++
 rtl/tt_mux_sel_driver.sv | 118 +++++++++++
 tb/tb_tt_mux_sel_driver.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/tt_mux_sel_pkg.sv
// Shared types and path-decision helpers for the TinyTapeout mux selection driver.
package tt_mux_sel_pkg;

   localparam int DEF_ADDR_W = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DIS,
      ST_RST_LO,
      ST_RST_HI,
      ST_INC_HI,
      ST_INC_LO,
      ST_SETTLE,
      ST_FIN
   } sel_state_e;

   // Counting up from the known address is only possible when it is known and not behind us.
   function automatic logic sel_full(input logic [31:0] addr, input logic [31:0] cur,
                                     input logic cur_valid, input logic force_rst);
      return !cur_valid || force_rst || (addr < cur);
   endfunction

   function automatic logic [31:0] sel_inc_count(input logic [31:0] addr, input logic [31:0] cur,
                                                 input logic full);
      return full ? addr : addr - cur;
   endfunction

endpackage

// File: rtl/tt_mux_sel_timer.sv
// Loadable down-counter shared by every timed state; tc is high once the count reaches zero.
module tt_mux_sel_timer #(
   parameter int TW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   output logic          tc
);

   logic [TW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              cnt <= '0;
      else if (load)           cnt <= load_val;
      else if (cnt != '0)      cnt <= cnt - TW'(1);
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/tt_mux_sel_driver.sv
// Selection-controller end of the TinyTapeout mux protocol: disables, resets/increments
// the mux address counter with timed pulses, settles and re-enables the target design.
module tt_mux_sel_driver
   import tt_mux_sel_pkg::*;
#(
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int PULSE_CYCLES  = 2,
   parameter int SETTLE_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_ena,
   input  logic              req_force_rst,
   output logic              ctrl_sel_rst_n,
   output logic              ctrl_sel_inc,
   output logic              ctrl_ena,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] cur_addr,
   output logic              cur_valid
);

   localparam int MAXC = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
   localparam int TW   = $clog2(MAXC) + 1;

   sel_state_e        state, nxt;
   logic [ADDR_W-1:0] addr_q, inc_cnt_q, path_cnt;
   logic              ena_q, force_q, started_q;
   logic              accept, full_path, tc, load;
   logic [TW-1:0]     load_val;

   assign accept    = req_valid && req_ready;
   assign full_path = sel_full(32'(addr_q), 32'(cur_addr), cur_valid, force_q);
   assign path_cnt  = ADDR_W'(sel_inc_count(32'(addr_q), 32'(cur_addr), full_path));

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE:   if (accept) nxt = ST_DIS;
         ST_DIS:    if (tc) nxt = full_path ? ST_RST_LO :
                                  ((path_cnt != '0) ? ST_INC_HI : ST_SETTLE);
         ST_RST_LO: if (tc) nxt = ST_RST_HI;
         ST_RST_HI: if (tc) nxt = (inc_cnt_q != '0) ? ST_INC_HI : ST_SETTLE;
         ST_INC_HI: if (tc) nxt = ST_INC_LO;
         // inc_cnt_q is decremented on this exit, so 1 means the last pulse just ended
         ST_INC_LO: if (tc) nxt = (inc_cnt_q != ADDR_W'(1)) ? ST_INC_HI : ST_SETTLE;
         ST_SETTLE: if (tc) nxt = ST_FIN;
         ST_FIN:    nxt = ST_IDLE;
         default:   nxt = ST_IDLE;
      endcase
   end

   // Every state change reloads the timer with the duration of the state being entered.
   assign load = (nxt != state);

   always_comb begin
      load_val = TW'(SETTLE_CYCLES - 1);
      case (nxt)
         ST_RST_LO, ST_RST_HI, ST_INC_HI, ST_INC_LO: load_val = TW'(PULSE_CYCLES - 1);
         default:                                    load_val = TW'(SETTLE_CYCLES - 1);
      endcase
   end

   tt_mux_sel_timer #(.TW(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (load_val),
      .tc       (tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         addr_q         <= '0;
         inc_cnt_q      <= '0;
         ena_q          <= 1'b0;
         force_q        <= 1'b0;
         started_q      <= 1'b0;
         cur_addr       <= '0;
         cur_valid      <= 1'b0;
         req_ready      <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         ctrl_sel_rst_n <= 1'b0;
         ctrl_sel_inc   <= 1'b0;
         ctrl_ena       <= 1'b0;
      end else begin
         state <= nxt;
         if (accept) begin
            addr_q    <= req_addr;
            ena_q     <= req_ena;
            force_q   <= req_force_rst;
            started_q <= 1'b1;
         end
         if (state == ST_DIS && tc) inc_cnt_q <= path_cnt;
         if (state == ST_RST_LO && tc) begin
            cur_addr  <= '0;
            cur_valid <= 1'b1;
         end
         if (state == ST_INC_HI && tc) cur_addr  <= cur_addr + ADDR_W'(1);
         if (state == ST_INC_LO && tc) inc_cnt_q <= inc_cnt_q - ADDR_W'(1);

         // Pins are registered from the next state so they line up with the state register.
         req_ready      <= (nxt == ST_IDLE);
         busy           <= (nxt != ST_IDLE);
         done           <= (nxt == ST_FIN);
         ctrl_sel_inc   <= (nxt == ST_INC_HI);
         ctrl_sel_rst_n <= (nxt != ST_RST_LO) && (started_q || accept);
         if (nxt == ST_FIN)       ctrl_ena <= ena_q;
         else if (nxt != ST_IDLE) ctrl_ena <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tt_mux_sel_driver.sv
// Scoreboard bench for tt_mux_sel_driver: expected latency/path/pulse counts queued at request time.
module tb_tt_mux_sel_driver;

   localparam int AW = 10;
   localparam int P  = 2;
   localparam int S  = 3;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          req_valid = 1'b0, req_ena = 1'b0, req_force_rst = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic          req_ready, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, busy, done, cur_valid;
   logic [AW-1:0] cur_addr;

   always #5 clk = ~clk;

   tt_mux_sel_driver #(.ADDR_W(AW), .PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_ena(req_ena), .req_force_rst(req_force_rst),
      .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena),
      .busy(busy), .done(done), .cur_addr(cur_addr), .cur_valid(cur_valid)
   );

   int n_chk = 0, n_fail = 0;
   int rst_lo_cyc = 0, inc_hi_cyc = 0, inc_rise = 0, viol = 0;
   logic inc_prev = 1'b0;
   int s_rst, s_hi, s_rise;

   typedef struct { int addr; bit ena; bit full; int n; int lat; } exp_t;
   exp_t sb[$];
   int   m_cur = 0;
   bit   m_cv  = 0;

   always @(negedge clk) if (rst_n) begin
      if (busy && !ctrl_sel_rst_n)     rst_lo_cyc <= rst_lo_cyc + 1;
      if (ctrl_sel_inc)                inc_hi_cyc <= inc_hi_cyc + 1;
      if (ctrl_sel_inc && !inc_prev)   inc_rise   <= inc_rise + 1;
      if (ctrl_sel_inc && !ctrl_sel_rst_n) viol   <= viol + 1;
      if (ctrl_ena && busy && !done)   viol       <= viol + 1;
      inc_prev <= ctrl_sel_inc;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1);
   end

   task automatic push_exp(input int addr, input bit ena, input bit frc);
      exp_t e;
      e.addr = addr; e.ena = ena;
      e.full = !m_cv || frc || (addr < m_cur);
      e.n    = e.full ? addr : addr - m_cur;
      e.lat  = 2*S + 1 + (e.full ? 2*P : 0) + 2*P*e.n;
      sb.push_back(e);
      m_cur = addr; m_cv = 1;
   endtask

   task automatic snap();
      s_rst = rst_lo_cyc; s_hi = inc_hi_cyc; s_rise = inc_rise;
   endtask

   // Returns at the negedge right after the accept edge (cycle 1 of the sequence).
   task automatic send(input int addr, input bit ena, input bit frc);
      logic [AW-1:0] a;
      push_exp(addr, ena, frc);
      a = AW'(addr);
      @(negedge clk);
      req_addr = a; req_ena = ena; req_force_rst = frc; req_valid = 1'b1;
      for (int k = 0; k < 100 && !req_ready; k++) @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      snap();
   endtask

   task automatic wait_done(output int lat);
      int c = 1;
      while (!done && c < 300) begin @(negedge clk); c++; end
      lat = done ? c : -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++; if ({ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, busy, done, cur_valid, req_ready} !== 7'b0) begin
         n_fail++; $display("FAIL reset_outs got %b want 0000000",
                            {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, busy, done, cur_valid, req_ready}); end
      n_chk++; if (cur_addr !== '0) begin n_fail++; $display("FAIL reset_cur_addr got %0d want 0", cur_addr); end
      rst_n = 1'b1;
      #1;
      n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge got %b want 0", req_ready); end
      @(negedge clk);
      n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge got %b want 1", req_ready); end
      n_chk++; if (ctrl_sel_rst_n !== 1'b0) begin n_fail++; $display("FAIL sel_rst_held got %b want 0", ctrl_sel_rst_n); end
   endtask

   task automatic test_paths();
      int   t_addr[6] = '{3, 5, 2, 5, 0, 0};
      bit   t_ena[6]  = '{1, 1, 1, 1, 0, 1};
      bit   t_frc[6]  = '{0, 0, 0, 1, 0, 0};
      exp_t e;
      int   lat;
      for (int i = 0; i < 6; i++) begin
         send(t_addr[i], t_ena[i], t_frc[i]);
         wait_done(lat);
         e = sb.pop_front();
         n_chk++; if (lat !== e.lat) begin n_fail++; $display("FAIL path%0d_latency got %0d want %0d", i, lat, e.lat); end
         n_chk++; if (cur_addr !== AW'(e.addr) || cur_valid !== 1'b1) begin n_fail++;
            $display("FAIL path%0d_cur got %0d/%b want %0d/1", i, cur_addr, cur_valid, e.addr); end
         n_chk++; if (ctrl_ena !== e.ena) begin n_fail++; $display("FAIL path%0d_ena got %b want %b", i, ctrl_ena, e.ena); end
         n_chk++; if (rst_lo_cyc - s_rst !== (e.full ? P : 0)) begin n_fail++;
            $display("FAIL path%0d_rst_cycles got %0d want %0d", i, rst_lo_cyc - s_rst, e.full ? P : 0); end
         n_chk++; if (inc_rise - s_rise !== e.n || inc_hi_cyc - s_hi !== e.n*P) begin n_fail++;
            $display("FAIL path%0d_incs got %0d/%0d want %0d/%0d", i, inc_rise - s_rise, inc_hi_cyc - s_hi, e.n, e.n*P); end
         @(negedge clk);
         n_chk++; if ({done, req_ready, ctrl_ena} !== {1'b0, 1'b1, e.ena}) begin n_fail++;
            $display("FAIL path%0d_after_done got %b want %b", i, {done, req_ready, ctrl_ena}, {1'b0, 1'b1, e.ena}); end
      end
   endtask

   task automatic test_busy_hold();
      exp_t ea, eb;
      int   c = 1, lat, rdy_busy = 0;
      send(4, 1, 0);
      push_exp(6, 1, 0);
      req_addr = AW'(6); req_ena = 1'b1; req_force_rst = 1'b0; req_valid = 1'b1;
      while (!done && c < 300) begin
         if (req_ready) rdy_busy++;
         @(negedge clk); c++;
      end
      ea = sb.pop_front();
      n_chk++; if ((done ? c : -1) !== ea.lat) begin n_fail++; $display("FAIL hold_a_latency got %0d want %0d", done ? c : -1, ea.lat); end
      n_chk++; if (rdy_busy !== 0) begin n_fail++; $display("FAIL hold_ready_busy got %0d want 0", rdy_busy); end
      n_chk++; if (cur_addr !== AW'(4) || req_ready !== 1'b0) begin n_fail++;
         $display("FAIL hold_a_done got %0d/%b want 4/0", cur_addr, req_ready); end
      @(negedge clk);
      n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL hold_ready_after got %b want 1", req_ready); end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      snap();
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_b_accept got %b want 1", busy); end
      wait_done(lat);
      eb = sb.pop_front();
      n_chk++; if (lat !== eb.lat || cur_addr !== AW'(eb.addr)) begin n_fail++;
         $display("FAIL hold_b_done got %0d/%0d want %0d/%0d", lat, cur_addr, eb.lat, eb.addr); end
      n_chk++; if (inc_rise - s_rise !== eb.n) begin n_fail++; $display("FAIL hold_b_incs got %0d want %0d", inc_rise - s_rise, eb.n); end
   endtask

   task automatic test_mid_reset();
      bit   seen_hi = 0, in_lo = 0;
      exp_t e;
      int   lat;
      send(7, 1, 0);
      for (int k = 0; k < 100 && !in_lo; k++) begin
         @(negedge clk);
         if (ctrl_sel_inc) seen_hi = 1;
         else if (seen_hi && busy) in_lo = 1;
      end
      n_chk++; if (in_lo !== 1'b1) begin n_fail++; $display("FAIL midrst_reach_inc_lo got %b want 1", in_lo); end
      rst_n = 1'b0;
      #1;
      n_chk++; if ({ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, busy, done, cur_valid, req_ready} !== 7'b0) begin
         n_fail++; $display("FAIL midrst_outs got %b want 0000000",
                            {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, busy, done, cur_valid, req_ready}); end
      n_chk++; if (cur_addr !== '0) begin n_fail++; $display("FAIL midrst_cur_addr got %0d want 0", cur_addr); end
      sb.delete();
      m_cv = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(1, 1, 0);
      wait_done(lat);
      e = sb.pop_front();
      n_chk++; if (lat !== e.lat || !e.full) begin n_fail++; $display("FAIL midrst_next_latency got %0d want %0d", lat, e.lat); end
      n_chk++; if (rst_lo_cyc - s_rst !== P) begin n_fail++; $display("FAIL midrst_next_rst got %0d want %0d", rst_lo_cyc - s_rst, P); end
      n_chk++; if (cur_addr !== AW'(1) || cur_valid !== 1'b1) begin n_fail++;
         $display("FAIL midrst_next_cur got %0d/%b want 1/1", cur_addr, cur_valid); end
   endtask

   task automatic test_invariants();
      @(negedge clk);
      n_chk++; if (viol !== 0) begin n_fail++; $display("FAIL pin_invariants got %0d violations want 0", viol); end
   endtask

   initial begin
      test_reset();
      test_paths();
      test_busy_hold();
      test_mid_reset();
      test_invariants();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
